mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the cpu, the move engine, the shared word memory and the arbiter.
// The arbiter connects as slave; the requesters and the memory model connect as master.
interface mem_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 31
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          mov_req;
  logic          mov_we;
  logic          mov_lock;
  logic [AW-1:0] mov_addr;
  logic [DW-1:0] mov_wdata;
  logic          mov_gnt;
  logic          mov_rvalid;
  logic [DW-1:0] mov_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  mov_req, mov_we, mov_lock, mov_addr, mov_wdata,
    output mov_gnt, mov_rvalid, mov_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output mov_req, mov_we, mov_lock, mov_addr, mov_wdata,
    input  mov_gnt, mov_rvalid, mov_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter (cpu vs. block-move engine) in front of one synchronous word memory.
// Zero-latency grant, round robin on ties, bounded burst lock for the move engine.
module mem_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int AW       = 12,
  parameter int DW       = 31
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    MOV  = 2'd2
  } owner_e;

  localparam logic       SEL_CPU  = 1'b0;
  localparam logic       SEL_MOV  = 1'b1;
  localparam logic [5:0] HOLD_MAX = 6'(MAX_HOLD);

  owner_e     owner_q, owner_d;
  logic       last_q, last_d;
  logic [5:0] hold_cnt_q, hold_cnt_d;
  logic       rd_sel_q, rd_sel_d;
  logic       rd_pend_q, rd_pend_d;
  logic       cpu_gnt_s, mov_gnt_s, lock_pref_s;

  // Grant decision; grants are forced low while reset is asserted.
  always_comb begin
    cpu_gnt_s   = 1'b0;
    mov_gnt_s   = 1'b0;
    lock_pref_s = bus.mov_lock && (owner_q == MOV) && (hold_cnt_q < HOLD_MAX);
    if (reset) begin
      cpu_gnt_s = 1'b0;
      mov_gnt_s = 1'b0;
    end else if (bus.cpu_req && bus.mov_req) begin
      // Locked burst keeps the bus until the hold budget runs out; otherwise alternate.
      if (lock_pref_s || (last_q == SEL_CPU)) begin
        mov_gnt_s = 1'b1;
      end else begin
        cpu_gnt_s = 1'b1;
      end
    end else begin
      cpu_gnt_s = bus.cpu_req;
      mov_gnt_s = bus.mov_req;
    end
  end

  // Memory-side mux; with no grant the cpu address and data pass through.
  always_comb begin
    bus.mem_en    = cpu_gnt_s | mov_gnt_s;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    if (mov_gnt_s) begin
      bus.mem_we    = bus.mov_we;
      bus.mem_addr  = bus.mov_addr;
      bus.mem_wdata = bus.mov_wdata;
    end else begin
      bus.mem_we    = cpu_gnt_s & bus.cpu_we;
    end
  end

  // Next state for owner, last grantee, hold counter and read return routing.
  always_comb begin
    owner_d    = owner_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    rd_sel_d   = rd_sel_q;
    rd_pend_d  = 1'b0;
    case ({cpu_gnt_s, mov_gnt_s})
      2'b10: begin
        owner_d   = CPU;
        last_d    = SEL_CPU;
        rd_sel_d  = SEL_CPU;
        rd_pend_d = ~bus.cpu_we;
      end
      2'b01: begin
        owner_d   = MOV;
        last_d    = SEL_MOV;
        rd_sel_d  = SEL_MOV;
        rd_pend_d = ~bus.mov_we;
      end
      default: begin
        owner_d = IDLE;
      end
    endcase
    if (cpu_gnt_s || !bus.mov_lock) begin
      hold_cnt_d = 6'd0;
    end else if (mov_gnt_s && bus.cpu_req && (hold_cnt_q < HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + 6'd1;
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  // State registers; last starts as MOV so the cpu wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q    <= IDLE;
      last_q     <= SEL_MOV;
      hold_cnt_q <= 6'd0;
      rd_sel_q   <= SEL_CPU;
      rd_pend_q  <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      rd_sel_q   <= rd_sel_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt_s;
  assign bus.mov_gnt    = mov_gnt_s;
  assign bus.cpu_rvalid = rd_pend_q & (rd_sel_q == SEL_CPU);
  assign bus.mov_rvalid = rd_pend_q & (rd_sel_q == SEL_MOV);
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.mov_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model, read-data scoreboard per port,
// and directed arbitration sequences with explicit expected grants.
module tb_mem_arbiter;
  localparam int AW       = 12;
  localparam int DW       = 31;
  localparam int MAX_HOLD = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus();

  mem_arbiter #(.MAX_HOLD(MAX_HOLD), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic [DW-1:0] cpu_q[$];
  logic [DW-1:0] mov_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Synchronous memory model driven by the arbiter's memory port.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  function automatic logic [DW-1:0] pat(input int i);
    return DW'(i * 40503 + 17);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_mov(input logic req, input logic we, input logic lock,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.mov_req = req; bus.mov_we = we; bus.mov_lock = lock; bus.mov_addr = a; bus.mov_wdata = d;
  endtask

  // One clock: check grant and memory port, score reads, then check read returns.
  task automatic step(input logic ecg, input logic emg);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ewe;
    logic [DW-1:0] exp_d;
    #1;
    check_val("cpu_gnt", 32'(bus.cpu_gnt), 32'(ecg));
    check_val("mov_gnt", 32'(bus.mov_gnt), 32'(emg));
    check_val("mem_en", 32'(bus.mem_en), 32'(ecg | emg));
    if (emg) begin
      ea = bus.mov_addr; ed = bus.mov_wdata; ewe = bus.mov_we;
    end else begin
      ea = bus.cpu_addr; ed = bus.cpu_wdata; ewe = ecg & bus.cpu_we;
    end
    check_val("mem_we", 32'(bus.mem_we), 32'(ewe));
    check_val("mem_addr", 32'(bus.mem_addr), 32'(ea));
    check_val("mem_wdata", 32'(bus.mem_wdata), 32'(ed));
    if (ecg && !bus.cpu_we) cpu_q.push_back(shadow[bus.cpu_addr]);
    if (ecg && bus.cpu_we)  shadow[bus.cpu_addr] = bus.cpu_wdata;
    if (emg && !bus.mov_we) mov_q.push_back(shadow[bus.mov_addr]);
    if (emg && bus.mov_we)  shadow[bus.mov_addr] = bus.mov_wdata;
    @(posedge clk);
    @(negedge clk);
    check_val("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(cpu_q.size() != 0));
    if (cpu_q.size() != 0) begin
      exp_d = cpu_q.pop_front();
      if (bus.cpu_rvalid) check_val("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_d));
    end
    check_val("mov_rvalid", 32'(bus.mov_rvalid), 32'(mov_q.size() != 0));
    if (mov_q.size() != 0) begin
      exp_d = mov_q.pop_front();
      if (bus.mov_rvalid) check_val("mov_rdata", 32'(bus.mov_rdata), 32'(exp_d));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_cpu(1'b1, 1'b0, 12'h000, 31'h0);
    set_mov(1'b1, 1'b0, 1'b1, 12'h001, 31'h0);
    #1;
    check_val("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'h0);
    check_val("rst_mov_gnt", 32'(bus.mov_gnt), 32'h0);
    check_val("rst_mem_en", 32'(bus.mem_en), 32'h0);
    check_val("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check_val("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    check_val("rst_mov_rvalid", 32'(bus.mov_rvalid), 32'h0);
    @(negedge clk);
    cpu_q.delete();
    mov_q.delete();
    set_cpu(1'b0, 1'b0, 12'h000, 31'h0);
    set_mov(1'b0, 1'b0, 1'b0, 12'h000, 31'h0);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]    = pat(i);
      shadow[i] = pat(i);
    end
    set_cpu(1'b0, 1'b0, 12'h000, 31'h0);
    set_mov(1'b0, 1'b0, 1'b0, 12'h000, 31'h0);
    @(negedge clk);
    do_reset();

    // Single cpu read, then idle with cpu address/data passing through.
    set_cpu(1'b1, 1'b0, 12'h010, 31'h0);
    step(1'b1, 1'b0);
    set_cpu(1'b0, 1'b1, 12'h3C3, 31'h155);
    step(1'b0, 1'b0);

    // Tie from reset without lock alternates starting with cpu.
    do_reset();
    set_cpu(1'b1, 1'b0, 12'h020, 31'h0);
    set_mov(1'b1, 1'b0, 1'b0, 12'h030, 31'h0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);

    // Locked burst: MAX_HOLD further mov grants, one cpu slot, then mov resumes.
    do_reset();
    set_mov(1'b1, 1'b0, 1'b1, 12'h100, 31'h0);
    step(1'b0, 1'b1);
    set_cpu(1'b1, 1'b0, 12'h200, 31'h0);
    for (int i = 0; i < MAX_HOLD; i++) begin
      set_mov(1'b1, 1'b0, 1'b1, 12'(12'h101 + i), 31'h0);
      step(1'b0, 1'b1);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    set_cpu(1'b0, 1'b0, 12'h000, 31'h0);
    set_mov(1'b0, 1'b0, 1'b0, 12'h000, 31'h0);
    step(1'b0, 1'b0);

    // Alternating single-requester reads return on consecutive cycles.
    for (int i = 0; i < 2; i++) begin
      set_cpu(1'b1, 1'b0, 12'h001, 31'h0);
      set_mov(1'b0, 1'b0, 1'b0, 12'h002, 31'h0);
      step(1'b1, 1'b0);
      set_cpu(1'b0, 1'b0, 12'h001, 31'h0);
      set_mov(1'b1, 1'b0, 1'b0, 12'h002, 31'h0);
      step(1'b0, 1'b1);
    end

    // Lock without a mov request does not block the cpu.
    set_mov(1'b0, 1'b0, 1'b1, 12'h040, 31'h0);
    set_cpu(1'b1, 1'b0, 12'h041, 31'h0);
    step(1'b1, 1'b0);

    // Move-engine write of the largest word at a high address, then cpu reads it back.
    set_cpu(1'b0, 1'b0, 12'h000, 31'h0);
    set_mov(1'b1, 1'b1, 1'b0, 12'hFA0, 31'h7FFFFFFF);
    step(1'b0, 1'b1);
    set_mov(1'b0, 1'b0, 1'b0, 12'h000, 31'h0);
    set_cpu(1'b1, 1'b0, 12'hFA0, 31'h0);
    step(1'b1, 1'b0);

    // Reset just after a read grant suppresses the pending rvalid.
    set_cpu(1'b1, 1'b0, 12'h050, 31'h0);
    #1;
    check_val("pre_rst_cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("mid_rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    check_val("mid_rst_cpu_gnt", 32'(bus.cpu_gnt), 32'h0);
    check_val("mid_rst_mem_en", 32'(bus.mem_en), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    check_val("post_rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    set_cpu(1'b1, 1'b0, 12'h060, 31'h0);
    set_mov(1'b1, 1'b0, 1'b0, 12'h061, 31'h0);
    step(1'b1, 1'b0);
    set_cpu(1'b0, 1'b0, 12'h000, 31'h0);
    set_mov(1'b0, 1'b0, 1'b0, 12'h000, 31'h0);
    step(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
